// File: rtl/noc_vc_output_port.sv
// noc_vc_output_port: per-VC flit FIFOs with credit-gated round-robin arbitration onto one registered output.
module noc_vc_output_port #(
    parameter int DATA_W = 16,
    parameter int DEPTH = 4,
    parameter int NUM_VC = 2,
    parameter int CREDITS = 5,
    localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [VC_W-1:0]   in_vc,
    input  logic [DATA_W-1:0] in_data,
    input  logic [NUM_VC-1:0] credit_inc,
    output logic [NUM_VC-1:0] full_o,
    output logic              out_valid,
    output logic [VC_W-1:0]   out_vc,
    output logic [DATA_W-1:0] out_data,
    output logic              err_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CR_W = $clog2(CREDITS + 1);

    logic [DATA_W-1:0] mem_q [NUM_VC][DEPTH];
    logic [DATA_W-1:0] mem_d [NUM_VC][DEPTH];
    logic [PTR_W-1:0]  rd_q [NUM_VC], rd_d [NUM_VC], wr_q [NUM_VC], wr_d [NUM_VC];
    logic [CNT_W-1:0]  cnt_q [NUM_VC], cnt_d [NUM_VC];
    logic [CR_W-1:0]   cred_q [NUM_VC], cred_d [NUM_VC];
    logic [VC_W-1:0]   rr_q, rr_d, out_vc_q, out_vc_d, gnt_vc, idx;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d, err_q, err_d;
    logic              in_ok, push, push_err, grant;
    logic [NUM_VC-1:0] elig, pu, po;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full_o = '0;
        elig = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            full_o[v] = cnt_q[v] == CNT_W'(DEPTH);
            elig[v] = (cnt_q[v] != '0) && (cred_q[v] != '0);
        end
        in_ok = int'(in_vc) < NUM_VC;
        push = in_valid && in_ok && !full_o[in_vc];
        push_err = in_valid && !push;
        grant = 1'b0;
        gnt_vc = '0;
        idx = '0;
        // search begins one past the last granted VC and wraps back to it last
        for (int i = 1; i <= NUM_VC; i++) begin
            idx = VC_W'((int'(rr_q) + i) % NUM_VC);
            if (!grant && elig[idx]) begin
                grant = 1'b1;
                gnt_vc = idx;
            end
        end
        pu = '0;
        po = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            pu[v] = push && (in_vc == VC_W'(v));
            po[v] = grant && (gnt_vc == VC_W'(v));
        end
    end

    always_comb begin
        mem_d = mem_q;
        err_d = err_q | push_err;
        rr_d = grant ? gnt_vc : rr_q;
        out_valid_d = grant;
        out_vc_d = grant ? gnt_vc : out_vc_q;
        out_data_d = grant ? mem_q[gnt_vc][rd_q[gnt_vc]] : out_data_q;
        for (int v = 0; v < NUM_VC; v++) begin
            rd_d[v] = po[v] ? nxt(rd_q[v]) : rd_q[v];
            wr_d[v] = pu[v] ? nxt(wr_q[v]) : wr_q[v];
            if (pu[v])
                mem_d[v][wr_q[v]] = in_data;
            cnt_d[v] = cnt_q[v] + CNT_W'(pu[v]) - CNT_W'(po[v]);
            // a return with a same-edge grant nets out; a lone return at the cap saturates and flags
            cred_d[v] = (credit_inc[v] && !po[v]) ? ((cred_q[v] == CR_W'(CREDITS)) ? cred_q[v] : cred_q[v] + 1'b1)
                      : (po[v] && !credit_inc[v]) ? cred_q[v] - 1'b1 : cred_q[v];
            err_d = err_d | (credit_inc[v] && !po[v] && (cred_q[v] == CR_W'(CREDITS)));
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                rd_q[v] <= '0;
                wr_q[v] <= '0;
                cnt_q[v] <= '0;
                cred_q[v] <= CR_W'(CREDITS);
            end
            rr_q <= VC_W'(NUM_VC - 1);
            out_valid_q <= 1'b0;
            out_vc_q <= '0;
            out_data_q <= '0;
            err_q <= 1'b0;
        end else begin
            rd_q <= rd_d;
            wr_q <= wr_d;
            cnt_q <= cnt_d;
            cred_q <= cred_d;
            rr_q <= rr_d;
            out_valid_q <= out_valid_d;
            out_vc_q <= out_vc_d;
            out_data_q <= out_data_d;
            err_q <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_vc = out_vc_q;
    assign out_data = out_data_q;
    assign err_o = err_q;
endmodule

// File: tb/tb_noc_vc_output_port.sv
// tb_noc_vc_output_port: directed checks of buffering, credits, arbitration, errors and reset.
module tb_noc_vc_output_port;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [0:0]  in_vc = '0;
    logic [15:0] in_data = '0;
    logic [1:0]  credit_inc = '0;
    logic [1:0]  full_o;
    logic        out_valid;
    logic [0:0]  out_vc;
    logic [15:0] out_data;
    logic        err_o;
    int vectors = 0;
    int miscompares = 0;

    noc_vc_output_port dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_vc(in_vc), .in_data(in_data),
        .credit_inc(credit_inc), .full_o(full_o), .out_valid(out_valid), .out_vc(out_vc),
        .out_data(out_data), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic [0:0] vc, input logic [15:0] d, input logic [1:0] ci);
        in_valid = v;
        in_vc = vc;
        in_data = d;
        credit_inc = ci;
    endtask

    task automatic chk_flit(input string tag, input logic [0:0] vc, input logic [15:0] d);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_vc"}, 32'(out_vc), 32'(vc));
        chk({tag, "_data"}, 32'(out_data), 32'(d));
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_vc"}, 32'(out_vc), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
        chk({tag, "_full"}, 32'(full_o), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 2'b00);
        tick();
        chk_rst("reset");
        rst = 1'b0;
    endtask

    initial begin
        // single flit latency
        do_reset();
        drive(1'b1, 1'b0, 16'h00A1, 2'b00);
        tick();
        chk("lat_e1_valid", 32'(out_valid), 32'd0);
        drive(1'b0, 1'b0, 16'h0, 2'b00);
        tick();
        chk_flit("lat_e2", 1'b0, 16'h00A1);
        tick();
        chk("lat_e3_valid", 32'(out_valid), 32'd0);
        chk("lat_e3_hold", 32'(out_data), 32'h00A1);

        // credit exhaustion on VC0, then a single return releases the held flit
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 1'b0, 16'(16'h10 + k - 1), 2'b00);
            tick();
            chk($sformatf("cred0_valid%0d", k), 32'(out_valid), 32'(k >= 2));
            if (k >= 2)
                chk($sformatf("cred0_data%0d", k), 32'(out_data), 32'(16'h10 + k - 2));
        end
        drive(1'b0, 1'b0, 16'h0, 2'b00);
        tick();
        chk("cred0_e7_valid", 32'(out_valid), 32'd0);
        tick();
        chk("cred0_e8_valid", 32'(out_valid), 32'd0);
        chk("cred0_e8_hold", 32'(out_data), 32'h14);
        drive(1'b0, 1'b0, 16'h0, 2'b01);
        tick();
        chk("cred0_e9_valid", 32'(out_valid), 32'd0);
        drive(1'b0, 1'b0, 16'h0, 2'b00);
        tick();
        chk_flit("cred0_e10", 1'b0, 16'h15);
        tick();
        chk("cred0_e11_valid", 32'(out_valid), 32'd0);
        chk("cred0_err", 32'(err_o), 32'd0);

        // VC1 starved and filled, overflow push dropped, VC0 unaffected
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            drive(1'b1, 1'b1, 16'(16'h20 + k - 1), 2'b00);
            tick();
            chk($sformatf("fill1_valid%0d", k), 32'(out_valid), 32'(k >= 2 && k <= 6));
            if (k >= 2 && k <= 6)
                chk($sformatf("fill1_data%0d", k), 32'(out_data), 32'(16'h20 + k - 2));
        end
        chk("fill1_full", 32'(full_o), 32'b10);
        chk("fill1_err0", 32'(err_o), 32'd0);
        drive(1'b1, 1'b1, 16'h29, 2'b00);
        tick();
        chk("fill1_drop_err", 32'(err_o), 32'd1);
        chk("fill1_drop_full", 32'(full_o), 32'b10);
        drive(1'b1, 1'b0, 16'h30, 2'b00);
        tick();
        chk("fill1_e11_valid", 32'(out_valid), 32'd0);
        drive(1'b0, 1'b0, 16'h0, 2'b10);
        tick();
        chk_flit("fill1_vc0", 1'b0, 16'h30);
        drive(1'b0, 1'b0, 16'h0, 2'b00);
        tick();
        chk_flit("fill1_vc1", 1'b1, 16'h25);
        chk("fill1_unfull", 32'(full_o), 32'b00);
        chk("fill1_err_sticky", 32'(err_o), 32'd1);
        tick();
        chk("fill1_e14_valid", 32'(out_valid), 32'd0);

        // interleaved traffic, then genuine contention after credits refill together
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'(k % 2), 16'(16'h40 + k), 2'b00);
            tick();
            if (k >= 1)
                chk_flit($sformatf("alt%0d", k), 1'((k - 1) % 2), 16'(16'h40 + k - 1));
        end
        drive(1'b0, 1'b0, 16'h0, 2'b00);
        tick();
        chk_flit("alt10", 1'b1, 16'h49);
        drive(1'b1, 1'b0, 16'h50, 2'b00);
        tick();
        chk("rr_load0", 32'(out_valid), 32'd0);
        drive(1'b1, 1'b1, 16'h60, 2'b00);
        tick();
        chk("rr_load1", 32'(out_valid), 32'd0);
        drive(1'b1, 1'b0, 16'h51, 2'b00);
        tick();
        chk("rr_load2", 32'(out_valid), 32'd0);
        drive(1'b1, 1'b1, 16'h61, 2'b00);
        tick();
        chk("rr_load3", 32'(out_valid), 32'd0);
        drive(1'b0, 1'b0, 16'h0, 2'b11);
        tick();
        chk("rr_e16_valid", 32'(out_valid), 32'd0);
        tick();
        chk_flit("rr_g0", 1'b0, 16'h50);
        drive(1'b0, 1'b0, 16'h0, 2'b00);
        tick();
        chk_flit("rr_g1", 1'b1, 16'h60);
        tick();
        chk_flit("rr_g2", 1'b0, 16'h51);
        tick();
        chk_flit("rr_g3", 1'b1, 16'h61);
        tick();
        chk("rr_idle", 32'(out_valid), 32'd0);
        chk("rr_err", 32'(err_o), 32'd0);

        // credit return at the cap is an error and does not grow the count
        do_reset();
        drive(1'b0, 1'b0, 16'h0, 2'b10);
        tick();
        chk("sat_err", 32'(err_o), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 1'b1, 16'(16'h70 + k - 1), 2'b00);
            tick();
            chk($sformatf("sat_valid%0d", k), 32'(out_valid), 32'(k >= 2));
            if (k >= 2)
                chk($sformatf("sat_data%0d", k), 32'(out_data), 32'(16'h70 + k - 2));
        end
        drive(1'b0, 1'b0, 16'h0, 2'b00);
        tick();
        chk("sat_held", 32'(out_valid), 32'd0);
        chk("sat_err_sticky", 32'(err_o), 32'd1);

        // return and grant at the same edge with one credit left
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 1'b0, 16'(16'h80 + k - 1), (k == 6) ? 2'b01 : 2'b00);
            tick();
            if (k >= 2)
                chk_flit($sformatf("same%0d", k), 1'b0, 16'(16'h80 + k - 2));
        end
        drive(1'b1, 1'b0, 16'h86, 2'b00);
        tick();
        chk_flit("same7", 1'b0, 16'h85);
        drive(1'b1, 1'b0, 16'h87, 2'b00);
        tick();
        chk("same8_valid", 32'(out_valid), 32'd0);
        chk("same_err", 32'(err_o), 32'd0);

        // reset while flits are buffered and one is on the output
        drive(1'b1, 1'b1, 16'h90, 2'b00);
        tick();
        chk("pre_rst_e9", 32'(out_valid), 32'd0);
        drive(1'b1, 1'b1, 16'h91, 2'b00);
        tick();
        chk_flit("pre_rst", 1'b1, 16'h90);
        rst = 1'b1;
        drive(1'b1, 1'b1, 16'h92, 2'b11);
        tick();
        chk_rst("mid_rst");
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 2'b00);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("post_rst_valid%0d", k), 32'(out_valid), 32'd0);
            chk($sformatf("post_rst_data%0d", k), 32'(out_data), 32'd0);
        end
        drive(1'b1, 1'b1, 16'hB1, 2'b00);
        tick();
        drive(1'b0, 1'b0, 16'h0, 2'b00);
        tick();
        chk_flit("post_rst_flit", 1'b1, 16'hB1);
        tick();
        chk("post_rst_end", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
